if_stage: RTL and testbench

- Instruction-fetch stage of the MIPS32 five-stage pipeline, directly upstream of the instruction ROM.
- Generates the PC and the ROM chip-enable, and redirects on branch or exception.
- Latches the ROM's combinational instruction together with its PC into the IF/ID pipeline register that feeds decode.
- Holds the PC and IF/ID register under pipeline-control stall and flush.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if_id_reg.sv | 42 ++++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared MIPS32 pipeline definitions: word widths, reset/NOP constants and the
// fetch FSM encoding used by the IF, ctrl, ROM and ID stages.
package if_stage_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID style pipeline register: clears on reset/flush, inserts a bubble when
// the upstream stage stalls alone, holds when the downstream stage stalls.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_stall_if,
  input  logic         i_stall_id,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_inst,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_inst
);

  logic [W-1:0] r_pc;
  logic [W-1:0] r_inst;

  // Flush beats stall; a lone upstream stall must not duplicate an instruction.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_pc   <= {W{1'b0}};
      r_inst <= {W{1'b0}};
    end else if (i_stall_if && !i_stall_id) begin
      r_pc   <= {W{1'b0}};
      r_inst <= {W{1'b0}};
    end else if (i_stall_id) begin
      r_pc   <= r_pc;
      r_inst <= r_inst;
    end else begin
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: PC generation with flush/stall/branch
// redirect, ROM chip-enable, and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_ce;
  logic [31:0]  w_fetch_inst;

  // IDLE spends one cycle with ce low so the first real fetch is RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ce    <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_ce    <= 1'b1;
          r_pc    <= r_pc;
        end
        RUN: begin
          r_state <= RUN;
          r_ce    <= 1'b1;
          // A branch arriving during stall_if is dropped; ctrl never asserts both.
          if (flush) begin
            r_pc <= new_pc;
          end else if (stall_if) begin
            r_pc <= r_pc;
          end else if (branch_flag_i) begin
            r_pc <= branch_target_addr_i;
          end else begin
            r_pc <= next_seq_pc(r_pc, 32'(PC_STEP));
          end
        end
        default: begin
          r_state <= IDLE;
          r_ce    <= 1'b0;
          r_pc    <= RESET_PC;
        end
      endcase
    end
  end

  assign w_fetch_inst = r_ce ? rom_inst_i : NOP_INST;

  if_id_reg #(.W(XLEN)) u_if_id_reg (
    .clk       (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_stall_if(stall_if),
    .i_stall_id(stall_id),
    .i_pc      (r_pc),
    .i_inst    (w_fetch_inst),
    .o_pc      (id_pc),
    .o_inst    (id_inst)
  );

  assign pc = r_pc;
  assign ce = r_ce;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: table of per-cycle vectors plus hand-written
// sequences for full stall, flush priority, PC wrap and mid-run reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic [31:0] rom_inst_i;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_tests;
  int n_fail;

  if_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_if            (stall_if),
    .stall_id            (stall_id),
    .flush               (flush),
    .new_pc              (new_pc),
    .branch_flag_i       (branch_flag_i),
    .branch_target_addr_i(branch_target_addr_i),
    .rom_inst_i          (rom_inst_i),
    .pc                  (pc),
    .ce                  (ce),
    .id_pc               (id_pc),
    .id_inst             (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: distinct nonzero word per address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rom_inst_i = rom_word(pc);

  typedef struct {
    logic        rst;
    logic        sif;
    logic        sid;
    logic        fl;
    logic [31:0] npc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_ce;
    logic [31:0] e_id_pc;
    logic [31:0] e_id_inst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic sif, input logic sid, input logic fl,
                              input logic [31:0] npc, input logic br, input logic [31:0] tgt,
                              input logic [31:0] e_pc, input logic e_ce,
                              input logic [31:0] e_id_pc, input logic [31:0] e_id_inst);
    vec_t v;
    v.rst = r; v.sif = sif; v.sid = sid; v.fl = fl; v.npc = npc; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ce = e_ce; v.e_id_pc = e_id_pc; v.e_id_inst = e_id_inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sif, input logic sid, input logic fl,
                       input logic [31:0] npc, input logic br, input logic [31:0] tgt);
    rst = r; stall_if = sif; stall_id = sid; flush = fl;
    new_pc = npc; branch_flag_i = br; branch_target_addr_i = tgt;
  endtask

  // Apply inputs, clock once, then compare all outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input vec_t v);
    drive(v.rst, v.sif, v.sid, v.fl, v.npc, v.br, v.tgt);
    @(posedge clk);
    #1;
    check({tag, ".pc"},      pc,      v.e_pc);
    check({tag, ".ce"},      {31'd0, ce}, {31'd0, v.e_ce});
    check({tag, ".id_pc"},   id_pc,   v.e_id_pc);
    check({tag, ".id_inst"}, id_inst, v.e_id_inst);
  endtask

  vec_t vecs[13];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //                rst   sif   sid   fl    npc    br    tgt     e_pc   e_ce  e_id_pc e_id_inst
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h00, 1'b1, 32'h00, 32'h0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h04, 1'b1, 32'h00, rom_word(32'h00));
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h04, rom_word(32'h04));
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h40, 1'b1, 32'h08, rom_word(32'h08));
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h44, 1'b1, 32'h40, rom_word(32'h40));
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h10, 1'b1, 32'h44, rom_word(32'h44));
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h10, 1'b1, 32'h00, 32'h0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h10, 1'b1, 32'h00, 32'h0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h14, 1'b1, 32'h10, rom_word(32'h10));
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  32'h18, 1'b1, 32'h10, rom_word(32'h10));

    for (int i = 0; i < 13; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i]);
    end

    // Full stall: everything holds for three cycles, then resumes.
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("fullstall%0d", i),
            mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h18, 1'b1, 32'h10, rom_word(32'h10)));
    end
    cycle("stall_release",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1C, 1'b1, 32'h18, rom_word(32'h18)));

    // Flush wins over stall_if and branch in the same cycle.
    cycle("flush_prio",
          mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h80, 32'h20, 1'b1, 32'h00, 32'h0));
    cycle("post_flush",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h24, 1'b1, 32'h20, rom_word(32'h20)));

    // Branch to the top of the address space, then wrap to zero.
    cycle("br_top",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h24, rom_word(32'h24)));
    cycle("wrap",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)));
    cycle("post_wrap",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1, 32'h0, rom_word(32'h0)));

    // Mid-run reset discards all state on that edge.
    cycle("midrun_rst",
          mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0));
    cycle("rst_release",
          mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
